// File: rtl/blink_pkg.sv
// Shared definitions for the blink controller.
//
// Holds the 2-bit channel mode encoding used by both the top-level
// configuration port (cfg_mode) and every channel instance.
package blink_pkg;

  // Channel operating modes, as written through cfg_mode.
  typedef enum logic [1:0] {
    MODE_OFF   = 2'd0,
    MODE_ON    = 2'd1,
    MODE_BLINK = 2'd2,
    MODE_BURST = 2'd3
  } mode_e;

endpackage : blink_pkg

// File: rtl/blink_chan.sv
// One light channel of the blink controller.
//
// Holds the channel's mode, half-period, tick counter, remaining burst
// pulses and the registered light output. The channel advances on every
// clock edge where tick_i is high, unless a write arrives on the same edge,
// in which case the write is applied and that tick is dropped.
//
// Ports:
//   clk      in   system clock, rising edge
//   rst_n    in   asynchronous active-low reset
//   tick_i   in   prescaler tick, one clk wide
//   we_i     in   decoded write enable for this channel
//   mode_i   in   new mode (blink_pkg::mode_e encoding)
//   half_i   in   new half-period in ticks (0 is treated as 1)
//   burst_i  in   pulse count for burst mode
//   light_o  out  registered light output
//   busy_o   out  burst pulses still remaining
module blink_chan
  import blink_pkg::*;
#(
  parameter int CNT_W   = 16,
  parameter int BURST_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               tick_i,
  input  logic               we_i,
  input  logic [1:0]         mode_i,
  input  logic [CNT_W-1:0]   half_i,
  input  logic [BURST_W-1:0] burst_i,
  output logic               light_o,
  output logic               busy_o
);

  mode_e              mode_q,  mode_d;
  logic [CNT_W-1:0]   half_q,  half_d;
  logic [CNT_W-1:0]   cnt_q,   cnt_d;
  logic [BURST_W-1:0] rem_q,   rem_d;
  logic               light_q, light_d;
  logic               halfEnd;
  mode_e              newMode;

  assign newMode = mode_e'(mode_i);

  // The last tick of a half-period; half_q is never zero, so half_q-1
  // cannot wrap and cnt stays within 0..half-1.
  assign halfEnd = (cnt_q == (half_q - CNT_W'(1)));

  // Next-state logic. A write restarts the channel from a clean state and
  // takes priority over a coincident tick. In burst mode a falling toggle
  // consumes one pulse; once no pulses remain the channel parks dark with
  // its counter cleared.
  always_comb begin
    mode_d  = mode_q;
    half_d  = half_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    light_d = light_q;

    if (we_i) begin
      mode_d = newMode;
      half_d = (half_i == '0) ? CNT_W'(1) : half_i;
      cnt_d  = '0;
      rem_d  = burst_i;
      case (newMode)
        MODE_OFF:   light_d = 1'b0;
        MODE_ON:    light_d = 1'b1;
        MODE_BLINK: light_d = 1'b1;
        MODE_BURST: light_d = (burst_i != '0);
        default:    light_d = 1'b0;
      endcase
    end else if (tick_i) begin
      case (mode_q)
        MODE_BLINK: begin
          if (halfEnd) begin
            light_d = ~light_q;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        MODE_BURST: begin
          if (rem_q != '0) begin
            if (halfEnd) begin
              cnt_d = '0;
              if (light_q) begin
                light_d = 1'b0;
                rem_d   = rem_q - BURST_W'(1);
              end else begin
                light_d = 1'b1;
              end
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end else begin
            light_d = 1'b0;
            cnt_d   = '0;
          end
        end
        default: ;
      endcase
    end
  end

  // Channel state registers; reset leaves the channel OFF with a
  // half-period of one tick so the counter compare is always well-defined.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q  <= MODE_OFF;
      half_q  <= CNT_W'(1);
      cnt_q   <= '0;
      rem_q   <= '0;
      light_q <= 1'b0;
    end else begin
      mode_q  <= mode_d;
      half_q  <= half_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      light_q <= light_d;
    end
  end

  assign light_o = light_q;
  assign busy_o  = (mode_q == MODE_BURST) && (rem_q != '0);

endmodule : blink_chan

// File: rtl/blink_ctrl.sv
// Multi-channel LED blink controller.
//
// A shared prescaler produces a one-cycle tick every PRESCALE clocks; each
// channel counts ticks independently and is configured at runtime through a
// single-cycle write port. Writes to channel indices outside the instantiated
// range are silently dropped.
//
// Ports:
//   clk        in   system clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   cfg_we     in   configuration write strobe
//   cfg_ch     in   target channel index
//   cfg_mode   in   0=OFF 1=ON 2=BLINK 3=BURST
//   cfg_half   in   half-period in ticks
//   cfg_burst  in   pulse count for BURST
//   light      out  registered light outputs, one per channel
//   busy       out  per-channel burst-in-progress flags
//   tick       out  registered prescaler tick
module blink_ctrl
  import blink_pkg::*;
#(
  parameter int PRESCALE = 50,
  parameter int CHANNELS = 4,
  parameter int CNT_W    = 16,
  parameter int BURST_W  = 4,
  parameter int CH_W     = $clog2(CHANNELS) + 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cfg_we,
  input  logic [CH_W-1:0]     cfg_ch,
  input  logic [1:0]          cfg_mode,
  input  logic [CNT_W-1:0]    cfg_half,
  input  logic [BURST_W-1:0]  cfg_burst,
  output logic [CHANNELS-1:0] light,
  output logic [CHANNELS-1:0] busy,
  output logic                tick
);

  // Keep the prescaler at least one bit wide so PRESCALE=1 still elaborates;
  // in that case the counter sits at zero and tick stays high.
  localparam int PC_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  logic [PC_W-1:0]     pc_q,   pc_d;
  logic                tick_q, tick_d;
  logic                chInRange;
  logic [CHANNELS-1:0] chWe;

  // Prescaler next state: wrap at PRESCALE-1 and raise tick for the
  // following cycle only.
  always_comb begin
    pc_d   = pc_q + PC_W'(1);
    tick_d = 1'b0;
    if (pc_q == PC_W'(PRESCALE - 1)) begin
      pc_d   = '0;
      tick_d = 1'b1;
    end
  end

  // Prescaler and tick registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q   <= '0;
      tick_q <= 1'b0;
    end else begin
      pc_q   <= pc_d;
      tick_q <= tick_d;
    end
  end

  assign tick = tick_q;

  // Decode the write port into one enable per channel. cfg_ch carries one
  // spare bit so an index past the last channel is representable and can
  // be rejected explicitly.
  assign chInRange = (cfg_ch < CH_W'(CHANNELS));

  always_comb begin
    chWe = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      chWe[i] = cfg_we && chInRange && (cfg_ch == CH_W'(i));
    end
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : gChan
    blink_chan #(
      .CNT_W   (CNT_W),
      .BURST_W (BURST_W)
    ) uChan (
      .clk     (clk),
      .rst_n   (rst_n),
      .tick_i  (tick_q),
      .we_i    (chWe[i]),
      .mode_i  (cfg_mode),
      .half_i  (cfg_half),
      .burst_i (cfg_burst),
      .light_o (light[i]),
      .busy_o  (busy[i])
    );
  end

endmodule : blink_ctrl
